// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution sequencer: operation and ALU
// encodings, sequencer FSM states and the beat-count helper.
package vec_pkg;

  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_VV   = 2'b01,
    OP_VS   = 2'b10,
    OP_RED  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Number of lane passes needed to cover v elements with l lanes.
  function automatic int calc_beats(input int v, input int l);
    return (v + l - 1) / l;
  endfunction

endpackage

// File: rtl/vec_exec_sequencer_alu.sv
// Single-lane combinational ALU: add, subtract (a-b), and, or; modulo 2^N.
module vec_exec_alu
  import vec_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   ctrl,
  output logic [N-1:0] y
);

  // Select the lane operation; wrap-around arithmetic, no flags.
  always_comb begin
    y = {N{1'b0}};
    case (alu_e'(ctrl))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/vec_exec_sequencer.sv
// Vector execution sequencer: captures a V-element operation on accept, then
// processes L elements per cycle through L ALU lanes, writing results into
// vector_o beat by beat, and pulses done_o for one cycle at the end.
// Optional feature macro: VEC_EXEC_REDUCE_EN (adds OpType=11 and reduce_o).
module vec_exec_sequencer
  import vec_pkg::*;
#(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start_i,
  input  logic [1:0]     OpType,
  input  logic [1:0]     ALUControl,
  input  logic [V*N-1:0] RD1_VEC_i,
  input  logic [V*N-1:0] RD2_VEC_i,
  input  logic [N-1:0]   Scalar_i,
  output logic           ready_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [V*N-1:0] vector_o
`ifdef VEC_EXEC_REDUCE_EN
  ,
  output logic [N-1:0]   reduce_o
`endif
);

  localparam int BEATS = calc_beats(V, L);
  // Operand/result arrays are padded to a whole number of beats so lane
  // indexing never leaves the array; padding slots are never written back.
  localparam int PADV  = BEATS * L;
  localparam int IDXW  = (PADV > 1) ? $clog2(PADV) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e            state_r;
  state_e            state_nx_s;
  logic              accept_s;
  logic              op_ok_s;
  logic              last_beat_s;
  logic [BW-1:0]     beat_r;
  op_e               op_r;
  logic [1:0]        ctrl_r;
  logic [N-1:0]      scalar_r;
  logic [N-1:0]      a_r   [PADV];
  logic [N-1:0]      b_r   [PADV];
  logic [N-1:0]      res_r [PADV];
  logic [PADV*N-1:0] rd1_pad_s;
  logic [PADV*N-1:0] rd2_pad_s;
  logic [N-1:0]      lane_a_s   [L];
  logic [N-1:0]      lane_b_s   [L];
  logic [N-1:0]      lane_y_s   [L];
  logic [IDXW-1:0]   lane_idx_s [L];
  logic [L-1:0]      lane_en_s;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;

  assign rd1_pad_s   = (PADV*N)'(RD1_VEC_i);
  assign rd2_pad_s   = (PADV*N)'(RD2_VEC_i);
  assign last_beat_s = (beat_r == BW'(BEATS - 1));

  // Decide which operation types are legal to accept in this build.
  always_comb begin
    op_ok_s = 1'b0;
    case (op_e'(OpType))
      OP_VV:   op_ok_s = 1'b1;
      OP_VS:   op_ok_s = 1'b1;
`ifdef VEC_EXEC_REDUCE_EN
      OP_RED:  op_ok_s = 1'b1;
`endif
      default: op_ok_s = 1'b0;
    endcase
  end

  // FSM next-state logic and accept strobe.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i && op_ok_s) begin
          state_nx_s = ST_RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_beat_s) state_nx_s = ST_DONE;
        else             state_nx_s = ST_RUN;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state register; reset wins over any request.
  always_ff @(posedge CLK) begin
    if (RST) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Status outputs registered from the next state so they track state_r.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_nx_s == ST_IDLE);
      busy_r  <= (state_nx_s == ST_RUN);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  assign ready_o = ready_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;

  // Route the current beat's captured elements to the lanes; lanes past V-1
  // in the final beat are disabled.
  always_comb begin
    for (int j = 0; j < L; j++) begin
      lane_en_s[j]  = ((int'(beat_r) * L + j) < V);
      lane_idx_s[j] = IDXW'(int'(beat_r) * L + j);
      lane_a_s[j]   = a_r[lane_idx_s[j]];
      lane_b_s[j]   = (op_r == OP_VS) ? scalar_r : b_r[lane_idx_s[j]];
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_lane
    vec_exec_alu #(.N(N)) u_alu (
      .a    (lane_a_s[g]),
      .b    (lane_b_s[g]),
      .ctrl (ctrl_r),
      .y    (lane_y_s[g])
    );
  end

  // Operand capture on accept, beat counter, and per-beat result write-back.
  always_ff @(posedge CLK) begin
    if (RST) begin
      beat_r   <= {BW{1'b0}};
      op_r     <= OP_RSVD;
      ctrl_r   <= 2'b00;
      scalar_r <= {N{1'b0}};
      for (int i = 0; i < PADV; i++) begin
        a_r[i]   <= {N{1'b0}};
        b_r[i]   <= {N{1'b0}};
        res_r[i] <= {N{1'b0}};
      end
    end else if (accept_s) begin
      beat_r   <= {BW{1'b0}};
      op_r     <= op_e'(OpType);
      ctrl_r   <= ALUControl;
      scalar_r <= Scalar_i;
      for (int i = 0; i < PADV; i++) begin
        a_r[i] <= rd1_pad_s[i*N +: N];
        b_r[i] <= rd2_pad_s[i*N +: N];
      end
    end else if (state_r == ST_RUN) begin
      for (int j = 0; j < L; j++) begin
        if (lane_en_s[j]) res_r[lane_idx_s[j]] <= lane_y_s[j];
      end
      beat_r <= last_beat_s ? {BW{1'b0}} : beat_r + BW'(1);
    end
  end

  for (genvar g = 0; g < V; g++) begin : g_out
    assign vector_o[g*N +: N] = res_r[g];
  end

`ifdef VEC_EXEC_REDUCE_EN
  logic [N-1:0] beat_sum_s;
  logic [N-1:0] reduce_r;

  // Sum of the enabled lane results of the current beat.
  always_comb begin
    beat_sum_s = {N{1'b0}};
    for (int j = 0; j < L; j++) begin
      beat_sum_s = beat_sum_s + (lane_en_s[j] ? lane_y_s[j] : {N{1'b0}});
    end
  end

  // Reduction accumulator: cleared on accept, summed each reduction beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      reduce_r <= {N{1'b0}};
    end else if (accept_s) begin
      reduce_r <= {N{1'b0}};
    end else if ((state_r == ST_RUN) && (op_r == OP_RED)) begin
      reduce_r <= reduce_r + beat_sum_s;
    end
  end

  assign reduce_o = reduce_r;
`endif

endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Self-checking bench for vec_exec_sequencer: table of directed operations on
// a V=20/L=4 instance, plus hand sequences for the V=10 instance, reset in
// RUN, start while busy, and reserved/reduction operation types.
module tb_vec_exec_sequencer;

  localparam int N  = 32;
  localparam int VA = 20;
  localparam int VB = 10;
  localparam int L  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start_a, start_b;
  logic [1:0]      op_a, ctrl_a, op_b, ctrl_b;
  logic [VA*N-1:0] rd1_a, rd2_a, vec_a;
  logic [VB*N-1:0] rd1_b, rd2_b, vec_b;
  logic [N-1:0]    sc_a, sc_b;
  logic            ready_a, busy_a, done_a, ready_b, busy_b, done_b;
`ifdef VEC_EXEC_REDUCE_EN
  logic [N-1:0]    red_a, red_b;
`endif

  vec_exec_sequencer #(.N(N), .V(VA), .L(L)) dut_a (
    .CLK(clk), .RST(rst), .start_i(start_a), .OpType(op_a), .ALUControl(ctrl_a),
    .RD1_VEC_i(rd1_a), .RD2_VEC_i(rd2_a), .Scalar_i(sc_a),
    .ready_o(ready_a), .busy_o(busy_a), .done_o(done_a), .vector_o(vec_a)
`ifdef VEC_EXEC_REDUCE_EN
    , .reduce_o(red_a)
`endif
  );

  vec_exec_sequencer #(.N(N), .V(VB), .L(L)) dut_b (
    .CLK(clk), .RST(rst), .start_i(start_b), .OpType(op_b), .ALUControl(ctrl_b),
    .RD1_VEC_i(rd1_b), .RD2_VEC_i(rd2_b), .Scalar_i(sc_b),
    .ready_o(ready_b), .busy_o(busy_b), .done_o(done_b), .vector_o(vec_b)
`ifdef VEC_EXEC_REDUCE_EN
    , .reduce_o(red_b)
`endif
  );

  typedef struct {
    logic [1:0]   op;
    logic [1:0]   ctrl;
    logic [N-1:0] sc;
    int           idx;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl [10];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] elem_a(input int i);
    return vec_a[i*N +: N];
  endfunction

  function automatic logic [N-1:0] elem_b(input int i);
    return vec_b[i*N +: N];
  endfunction

  // Issue one request on dut_a and count cycles from the request cycle to
  // the cycle where done_o is seen (bounded).
  task automatic run_a(input logic [1:0] op, input logic [1:0] ctrl,
                       input logic [N-1:0] sc, output int lat);
    op_a = op; ctrl_a = ctrl; sc_a = sc; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 1;
    while (!done_a && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dn;
    tbl[0] = '{2'b01, 2'b00, 32'd0,         0,  32'd0};
    tbl[1] = '{2'b01, 2'b00, 32'd0,         19, 32'd57};
    tbl[2] = '{2'b10, 2'b01, 32'd3,         0,  32'hFFFF_FFFD};
    tbl[3] = '{2'b10, 2'b01, 32'd3,         19, 32'd16};
    tbl[4] = '{2'b01, 2'b01, 32'd0,         5,  32'hFFFF_FFFB};
    tbl[5] = '{2'b01, 2'b10, 32'd0,         7,  32'd6};
    tbl[6] = '{2'b01, 2'b11, 32'd0,         9,  32'd27};
    tbl[7] = '{2'b10, 2'b11, 32'h0000_0100, 3,  32'h0000_0103};
    tbl[8] = '{2'b10, 2'b10, 32'h0000_000F, 18, 32'd2};
    tbl[9] = '{2'b01, 2'b00, 32'd0,         12, 32'd36};

    for (int i = 0; i < VA; i++) begin
      rd1_a[i*N +: N] = N'(i);
      rd2_a[i*N +: N] = N'(2 * i);
    end
    for (int i = 0; i < VB; i++) begin
      rd1_b[i*N +: N] = N'(i);
      rd2_b[i*N +: N] = N'(2 * i);
    end
    start_a = 1'b0; op_a = 2'b00; ctrl_a = 2'b00; sc_a = 32'd0;
    start_b = 1'b0; op_b = 2'b00; ctrl_b = 2'b00; sc_b = 32'd0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_busy",  {31'd0, busy_a},  32'd0);
    check("rst_done",  {31'd0, done_a},  32'd0);
    check("rst_vec",   {31'd0, |vec_a},  32'd0);
    check("rst_ready_b", {31'd0, ready_b}, 32'd1);

    // Full vector-vector add: every element and completion timing.
    run_a(2'b01, 2'b00, 32'd0, lat);
    check("vv_add_latency", 32'(lat), 32'd6);
    for (int i = 0; i < VA; i++) check($sformatf("vv_add_elem%0d", i), elem_a(i), N'(3 * i));
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done_a}, 32'd0);
    check("ready_after_done", {31'd0, ready_a}, 32'd1);

    // Table of directed operations.
    for (int k = 0; k < 10; k++) begin
      run_a(tbl[k].op, tbl[k].ctrl, tbl[k].sc, lat);
      check($sformatf("tbl%0d_latency", k), 32'(lat), 32'd6);
      check($sformatf("tbl%0d_elem%0d", k, tbl[k].idx), elem_a(tbl[k].idx), tbl[k].exp);
      @(posedge clk); #1;
    end

    // V=10, L=4: three beats with a partial last beat.
    op_b = 2'b01; ctrl_b = 2'b00; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("v10_latency", 32'(lat), 32'd4);
    check("v10_elem8", elem_b(8), 32'd24);
    check("v10_elem9", elem_b(9), 32'd27);
    check("v10_elem3", elem_b(3), 32'd9);
    @(posedge clk); #1;

    // start_i held in RUN with changed inputs: ignored, single done.
    op_a = 2'b01; ctrl_a = 2'b00; start_a = 1'b1;
    @(posedge clk); #1;
    op_a = 2'b10; ctrl_a = 2'b01;
    rd1_a = {VA*N{1'b1}};
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) start_a = 1'b0;
      if (done_a) dn++;
      @(posedge clk); #1;
    end
    check("start_in_run_dones", 32'(dn), 32'd1);
    check("start_in_run_elem5", elem_a(5), 32'd15);
    check("start_in_run_elem19", elem_a(19), 32'd57);
    for (int i = 0; i < VA; i++) rd1_a[i*N +: N] = N'(i);

    // Reserved OpType=00 is not accepted.
    op_a = 2'b00; ctrl_a = 2'b01; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("rsvd_ready", {31'd0, ready_a}, 32'd1);
    check("rsvd_busy",  {31'd0, busy_a},  32'd0);
    check("rsvd_elem5", elem_a(5), 32'd15);

`ifdef VEC_EXEC_REDUCE_EN
    // Reduction: element-wise add plus running sum.
    run_a(2'b11, 2'b00, 32'd0, lat);
    check("red_latency", 32'(lat), 32'd6);
    check("red_sum", red_a, 32'd570);
    check("red_elem19", elem_a(19), 32'd57);
    @(posedge clk); #1;
`else
    // OpType=11 is reserved in this build.
    op_a = 2'b11; ctrl_a = 2'b00; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("op11_ready", {31'd0, ready_a}, 32'd1);
    check("op11_busy",  {31'd0, busy_a},  32'd0);
`endif

    // Reset during the third RUN cycle abandons the operation.
    op_a = 2'b01; ctrl_a = 2'b01; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_vec_zero", {31'd0, |vec_a}, 32'd0);
    check("midrun_ready", {31'd0, ready_a}, 32'd1);
    check("midrun_busy",  {31'd0, busy_a},  32'd0);
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_a) dn++;
      @(posedge clk); #1;
    end
    check("midrun_no_done", 32'(dn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
